// File: rtl/mps_intl_manager.sv
// mps_intl_manager: parametrised interlock aggregator.
// Each raw source is synchronised, debounced on assertion only, masked and
// optionally latched. The block reports the OR of all channel states, the first
// channel to trip since the last clear, and a saturating count of flag rising edges.
module mps_intl_manager #(
   parameter int NUM_CH = 32,
   parameter int DB_W   = 8,
   parameter int TRIP_W = 16
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [NUM_CH-1:0]         i_intl_raw,
   input  logic [NUM_CH-1:0]         i_mask,
   input  logic [NUM_CH-1:0]         i_latch_en,
   input  logic [DB_W-1:0]           i_db_len,
   input  logic                      i_clr,
   output logic [NUM_CH-1:0]         o_intl_state,
   output logic                      o_intl_flag,
   output logic [$clog2(NUM_CH)-1:0] o_first_ch,
   output logic                      o_first_vld,
   output logic [TRIP_W-1:0]         o_trip_cnt,
   output logic                      o_clr_done
);

   localparam int CH_W = $clog2(NUM_CH);

   // Lowest set bit of a channel vector; zero when the vector is empty.
   function automatic logic [CH_W-1:0] lowest_idx(input logic [NUM_CH-1:0] vec);
      logic [CH_W-1:0] idx;
      idx = {CH_W{1'b0}};
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx = CH_W'(i);
         end
      end
      return idx;
   endfunction

   logic [NUM_CH-1:0] sync1_r;
   logic [NUM_CH-1:0] sync2_r;
   logic [DB_W-1:0]   cnt_r     [NUM_CH];
   logic [DB_W-1:0]   cnt_nxt_s [NUM_CH];
   logic [DB_W-1:0]   db_len_s;
   logic [NUM_CH-1:0] qual_s;
   logic [NUM_CH-1:0] next_state_s;
   logic [NUM_CH-1:0] new_s;
   logic [NUM_CH-1:0] state_r;
   logic [CH_W-1:0]   first_ch_r;
   logic [CH_W-1:0]   first_ch_nxt_s;
   logic              first_vld_r;
   logic              first_vld_nxt_s;
   logic              trip_inc_s;
   logic [TRIP_W-1:0] trip_cnt_r;
   logic              clr_done_r;

   // A debounce length of zero behaves like one so a channel can always qualify.
   always_comb begin
      if (i_db_len == {DB_W{1'b0}}) begin
         db_len_s = {{(DB_W-1){1'b0}}, 1'b1};
      end else begin
         db_len_s = i_db_len;
      end
   end

   // Debounce counters saturate at the length; the qualified level needs a full count.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (sync2_r[i]) begin
            if (cnt_r[i] >= db_len_s) begin
               cnt_nxt_s[i] = db_len_s;
            end else begin
               cnt_nxt_s[i] = cnt_r[i] + {{(DB_W-1){1'b0}}, 1'b1};
            end
         end else begin
            cnt_nxt_s[i] = {DB_W{1'b0}};
         end
         qual_s[i] = sync2_r[i] & (cnt_r[i] == db_len_s);
      end
   end

   // Per-channel next state: mask, then follow mode, then set-over-clear latching.
   always_comb begin
      next_state_s = {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
         if (i_mask[i]) begin
            next_state_s[i] = 1'b0;
         end else if (!i_latch_en[i]) begin
            next_state_s[i] = qual_s[i];
         end else if (qual_s[i]) begin
            next_state_s[i] = 1'b1;
         end else if (i_clr) begin
            next_state_s[i] = 1'b0;
         end else begin
            next_state_s[i] = state_r[i];
         end
      end
      new_s      = next_state_s & ~state_r;
      trip_inc_s = (state_r == {NUM_CH{1'b0}}) && (next_state_s != {NUM_CH{1'b0}});
   end

   // First-fault capture; channels that survive a clear are recaptured one edge later.
   always_comb begin
      first_ch_nxt_s  = first_ch_r;
      first_vld_nxt_s = first_vld_r;
      if ((new_s != {NUM_CH{1'b0}}) && (!first_vld_r || i_clr)) begin
         first_ch_nxt_s  = lowest_idx(new_s);
         first_vld_nxt_s = 1'b1;
      end else if (i_clr) begin
         first_vld_nxt_s = 1'b0;
      end else if (!first_vld_r && (next_state_s != {NUM_CH{1'b0}})) begin
         first_ch_nxt_s  = lowest_idx(next_state_s);
         first_vld_nxt_s = 1'b1;
      end else begin
         first_vld_nxt_s = first_vld_r;
      end
   end

   // Synchroniser and debounce counter registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sync1_r <= {NUM_CH{1'b0}};
         sync2_r <= {NUM_CH{1'b0}};
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_r[i] <= {DB_W{1'b0}};
         end
      end else begin
         sync1_r <= i_intl_raw;
         sync2_r <= sync1_r;
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_r[i] <= cnt_nxt_s[i];
         end
      end
   end

   // Interlock state, first-fault, trip counter and clear acknowledge registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r     <= {NUM_CH{1'b0}};
         first_ch_r  <= {CH_W{1'b0}};
         first_vld_r <= 1'b0;
         trip_cnt_r  <= {TRIP_W{1'b0}};
         clr_done_r  <= 1'b0;
      end else begin
         state_r     <= next_state_s;
         first_ch_r  <= first_ch_nxt_s;
         first_vld_r <= first_vld_nxt_s;
         clr_done_r  <= i_clr;
         if (trip_inc_s && (trip_cnt_r != {TRIP_W{1'b1}})) begin
            trip_cnt_r <= trip_cnt_r + {{(TRIP_W-1){1'b0}}, 1'b1};
         end else begin
            trip_cnt_r <= trip_cnt_r;
         end
      end
   end

   assign o_intl_state = state_r;
   assign o_intl_flag  = |state_r;
   assign o_first_ch   = first_ch_r;
   assign o_first_vld  = first_vld_r;
   assign o_trip_cnt   = trip_cnt_r;
   assign o_clr_done   = clr_done_r;

endmodule

// File: tb/tb_mps_intl_manager.sv
// tb_mps_intl_manager: directed scenarios plus randomized traffic checked against
// a history-based reference model of the interlock manager (8 channels).
module tb_mps_intl_manager;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  raw, mask, latch;
   logic [7:0]  db_len;
   logic        clr;
   logic [7:0]  state;
   logic        flag;
   logic [2:0]  first_ch;
   logic        first_vld;
   logic [15:0] trip_cnt;
   logic        clr_done;

   int errors = 0;
   int checks = 0;

   // reference model
   bit [7:0]  hist[$];
   bit [7:0]  m_st;
   bit        m_vld;
   bit [2:0]  m_first;
   bit [15:0] m_trip;
   bit        m_clr_done;

   mps_intl_manager #(.NUM_CH(8), .DB_W(8), .TRIP_W(16)) dut (
      .i_clk(clk), .i_rst(rst), .i_intl_raw(raw), .i_mask(mask), .i_latch_en(latch),
      .i_db_len(db_len), .i_clr(clr), .o_intl_state(state), .o_intl_flag(flag),
      .o_first_ch(first_ch), .o_first_vld(first_vld), .o_trip_cnt(trip_cnt),
      .o_clr_done(clr_done));

   always #5 clk = ~clk;

   function automatic bit [2:0] lowest(input bit [7:0] v);
      bit [2:0] r = 3'd0;
      for (int i = 7; i >= 0; i--) if (v[i]) r = 3'(i);
      return r;
   endfunction

   // One clock edge: the model consumes the inputs seen at the edge, outputs sampled 1 after.
   task automatic tick();
      int       len;
      bit [7:0] q, nx, nw;
      @(posedge clk);
      if (rst) begin
         hist.delete();
         m_st = 8'h00; m_vld = 1'b0; m_first = 3'd0; m_trip = 16'd0; m_clr_done = 1'b0;
      end else begin
         len = (db_len == 8'd0) ? 1 : int'(db_len);
         // a channel qualifies once its raw input was seen high on L+1 consecutive
         // edges, counted from two edges ago (synchroniser delay)
         for (int i = 0; i < 8; i++) begin
            q[i] = 1'b1;
            for (int j = 1; j <= len + 1; j++)
               if (j >= hist.size() || !hist[j][i]) q[i] = 1'b0;
         end
         for (int i = 0; i < 8; i++) begin
            if (mask[i])        nx[i] = 1'b0;
            else if (!latch[i]) nx[i] = q[i];
            else if (q[i])      nx[i] = 1'b1;
            else if (clr)       nx[i] = 1'b0;
            else                nx[i] = m_st[i];
         end
         nw = nx & ~m_st;
         if (nw != 8'h00 && (!m_vld || clr)) begin
            m_first = lowest(nw); m_vld = 1'b1;
         end else if (clr) begin
            m_vld = 1'b0;
         end else if (!m_vld && nx != 8'h00) begin
            m_first = lowest(nx); m_vld = 1'b1;
         end
         if (m_st == 8'h00 && nx != 8'h00 && m_trip != 16'hFFFF) m_trip = m_trip + 16'd1;
         m_clr_done = clr;
         m_st = nx;
         hist.push_front(raw);
         if (hist.size() > 40) void'(hist.pop_back());
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; raw = 8'h00; mask = 8'h00; latch = 8'hFF; db_len = 8'd4; clr = 1'b0;
      tick(); tick();
      rst = 1'b0;
      checks++; if (state !== 8'h00) begin errors++; $display("FAIL reset_state got=%h exp=00", state); end
      checks++; if (flag !== 1'b0) begin errors++; $display("FAIL reset_flag got=%b exp=0", flag); end
      checks++; if (first_vld !== 1'b0 || first_ch !== 3'd0) begin errors++; $display("FAIL reset_first got=%b/%0d exp=0/0", first_vld, first_ch); end
      checks++; if (trip_cnt !== 16'd0) begin errors++; $display("FAIL reset_trip got=%0d exp=0", trip_cnt); end
      checks++; if (clr_done !== 1'b0) begin errors++; $display("FAIL reset_clr_done got=%b exp=0", clr_done); end
   endtask

   task automatic test_latch_trip();
      for (int e = 1; e <= 14; e++) begin
         raw = (e <= 10) ? 8'h08 : 8'h00;
         tick();
         checks++; if (state[3] !== (e >= 7)) begin errors++; $display("FAIL latch_state3 edge=%0d got=%b exp=%b", e, state[3], (e >= 7)); end
         if (e == 7) begin
            checks++; if (flag !== 1'b1 || first_ch !== 3'd3 || first_vld !== 1'b1 || trip_cnt !== 16'd1) begin
               errors++; $display("FAIL latch_trip got flag=%b first=%0d vld=%b trip=%0d exp 1/3/1/1", flag, first_ch, first_vld, trip_cnt);
            end
         end
      end
   endtask

   task automatic test_glitch();
      for (int e = 1; e <= 10; e++) begin
         raw = (e <= 3) ? 8'h20 : 8'h00;
         tick();
         checks++; if (state !== 8'h08 || trip_cnt !== 16'd1) begin errors++; $display("FAIL glitch edge=%0d got state=%h trip=%0d exp 08/1", e, state, trip_cnt); end
      end
   endtask

   task automatic test_clear();
      raw = 8'h08;
      repeat (8) tick();
      clr = 1'b1; tick(); clr = 1'b0;
      checks++; if (state !== 8'h08 || first_vld !== 1'b0 || clr_done !== 1'b1) begin
         errors++; $display("FAIL clr_survive got state=%h vld=%b done=%b exp 08/0/1", state, first_vld, clr_done);
      end
      tick();
      checks++; if (first_vld !== 1'b1 || first_ch !== 3'd3 || clr_done !== 1'b0) begin
         errors++; $display("FAIL clr_recapture got vld=%b first=%0d done=%b exp 1/3/0", first_vld, first_ch, clr_done);
      end
      raw = 8'h00;
      repeat (3) tick();
      clr = 1'b1; tick(); clr = 1'b0;
      checks++; if (state !== 8'h00 || flag !== 1'b0 || first_vld !== 1'b0) begin
         errors++; $display("FAIL clr_clear got state=%h flag=%b vld=%b exp 00/0/0", state, flag, first_vld);
      end
   endtask

   task automatic test_first_fault();
      raw = 8'h44;
      repeat (7) tick();
      checks++; if (state !== 8'h44 || first_ch !== 3'd2 || first_vld !== 1'b1 || trip_cnt !== 16'd2) begin
         errors++; $display("FAIL first_pair got state=%h first=%0d vld=%b trip=%0d exp 44/2/1/2", state, first_ch, first_vld, trip_cnt);
      end
      raw = 8'h45;
      repeat (7) tick();
      checks++; if (state !== 8'h45 || first_ch !== 3'd2) begin
         errors++; $display("FAIL first_later got state=%h first=%0d exp 45/2", state, first_ch);
      end
      raw = 8'h00;
      repeat (3) tick();
      clr = 1'b1; tick(); clr = 1'b0;
      checks++; if (state !== 8'h00) begin errors++; $display("FAIL first_clear got=%h exp=00", state); end
   endtask

   task automatic test_nonlatch_mask();
      logic [15:0] trip0;
      latch = 8'hFD;
      trip0 = trip_cnt;
      for (int p = 0; p < 2; p++) begin
         for (int e = 1; e <= 14; e++) begin
            raw = (e <= 8) ? 8'h02 : 8'h00;
            tick();
            checks++; if (state[1] !== (e >= 7 && e <= 10)) begin
               errors++; $display("FAIL follow_state1 pulse=%0d edge=%0d got=%b exp=%b", p, e, state[1], (e >= 7 && e <= 10));
            end
         end
      end
      checks++; if (trip_cnt !== trip0 + 16'd2) begin errors++; $display("FAIL follow_trip got=%0d exp=%0d", trip_cnt, trip0 + 16'd2); end
      latch = 8'hFF;
      raw = 8'h08;
      repeat (7) tick();
      mask = 8'h08; tick();
      checks++; if (state[3] !== 1'b0) begin errors++; $display("FAIL mask_state3 got=%b exp=0", state[3]); end
      raw = 8'h00;
      repeat (3) tick();
      mask = 8'h00;
   endtask

   task automatic test_reset_mid_trip();
      raw = 8'h0C;
      repeat (7) tick();
      checks++; if (state !== 8'h0C || trip_cnt !== m_trip || trip_cnt == 16'd0) begin
         errors++; $display("FAIL pre_reset got state=%h trip=%0d exp 0C/%0d", state, trip_cnt, m_trip);
      end
      rst = 1'b1; tick(); rst = 1'b0;
      checks++; if (state !== 8'h00 || flag !== 1'b0 || first_vld !== 1'b0 || first_ch !== 3'd0 || trip_cnt !== 16'd0 || clr_done !== 1'b0) begin
         errors++; $display("FAIL mid_reset got state=%h flag=%b vld=%b first=%0d trip=%0d done=%b exp all 0", state, flag, first_vld, first_ch, trip_cnt, clr_done);
      end
      for (int e = 1; e <= 7; e++) begin
         tick();
         checks++; if (state !== ((e == 7) ? 8'h0C : 8'h00)) begin
            errors++; $display("FAIL retrip edge=%0d got=%h exp=%h", e, state, ((e == 7) ? 8'h0C : 8'h00));
         end
      end
      raw = 8'h00;
      repeat (3) tick();
      clr = 1'b1; tick(); clr = 1'b0;
   endtask

   task automatic test_random();
      bit [7:0] flip;
      for (int ph = 0; ph < 4; ph++) begin
         raw = 8'h00; clr = 1'b0; rst = 1'b0;
         repeat (4) tick();
         case (ph)
            0:       db_len = 8'd0;
            1:       db_len = 8'd1;
            2:       db_len = 8'd3;
            default: db_len = 8'd6;
         endcase
         for (int c = 0; c < 500; c++) begin
            flip = 8'h00;
            for (int i = 0; i < 8; i++) flip[i] = ($urandom_range(0, 7) == 0);
            raw = raw ^ flip;
            if ($urandom_range(0, 31) == 0) mask = 8'($urandom) & 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 31) == 0) latch = 8'($urandom);
            clr = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 299) == 0);
            tick();
            checks++; if (state !== m_st || flag !== (m_st != 8'h00)) begin
               errors++; $display("FAIL rnd_state ph=%0d c=%0d got=%h/%b exp=%h", ph, c, state, flag, m_st);
            end
            checks++; if (first_vld !== m_vld || (m_vld && first_ch !== m_first)) begin
               errors++; $display("FAIL rnd_first ph=%0d c=%0d got=%b/%0d exp=%b/%0d", ph, c, first_vld, first_ch, m_vld, m_first);
            end
            checks++; if (trip_cnt !== m_trip || clr_done !== m_clr_done) begin
               errors++; $display("FAIL rnd_trip ph=%0d c=%0d got=%0d/%b exp=%0d/%b", ph, c, trip_cnt, clr_done, m_trip, m_clr_done);
            end
         end
      end
      rst = 1'b0; clr = 1'b0;
   endtask

   initial begin
      test_reset();
      test_latch_trip();
      test_glitch();
      test_clear();
      test_first_fault();
      test_nonlatch_mask();
      test_reset_mid_trip();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
